// File: rtl/alul_arbiter_if.sv
// ---------------------------------------------------------------------------
// alul_arbiter_if
//   Bundles the request, ALU and response channels of alul_arbiter.
//
//   Request channel (per requester i, i = 0/1):
//     req_valid[i], req_ready[i]
//     req_a/req_b packed as [i*WIDTH +: WIDTH], req_s packed as [2i +: 2]
//   ALU channel : alu_a, alu_b, alu_s (to ALU), alu_out (from ALU)
//   Response    : rsp_valid, rsp_ready, rsp_id, rsp_data
//
//   Modports:
//     slave  - the arbiter side (consumes requests, drives the ALU/response)
//     master - the environment side (clients, ALU instance, consumer)
// ---------------------------------------------------------------------------
interface alul_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [3:0]         req_s;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [1:0]         alu_s;
    logic [WIDTH-1:0]   alu_out;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_data;

    modport slave (
        input  req_valid, req_a, req_b, req_s, alu_out, rsp_ready,
        output req_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, req_s, alu_out, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alul_arbiter.sv
// ---------------------------------------------------------------------------
// alul_arbiter
//   Shares one external 8-bit logic ALU (AND/OR/XOR/NOT A) between two
//   requesters. One op at a time: grant, drive registered operands to the
//   ALU, wait ALU_LAT cycles, capture alu_out, return it with the requester
//   ID on the response channel.
//
//   Handshakes (both channels): a transfer happens on a rising clk edge
//   where valid and ready are both 1. Requesters may drop req_valid before
//   being granted. The arbiter holds rsp_valid/rsp_id/rsp_data stable until
//   the transfer completes.
//
//   Ports:
//     clk        - sole clock, rising edge
//     rst        - synchronous, active-high reset
//     bus        - alul_arbiter_if.slave (request, ALU and response signals)
//     busy       - high whenever the FSM is not IDLE
//     state_dbg  - current FSM state (0=IDLE, 1=EXEC, 2=RESP)
//
//   Parameters:
//     WIDTH      - operand/result width, must match the ALU instance
//     ALU_LAT    - cycles operands are held before alu_out is captured, 1..15
//
//   Build option:
//     ALUL_ARB_FIXED_PRIORITY_EN - when defined, requester 0 always wins a
//     tie and the round-robin pointer is removed.
// ---------------------------------------------------------------------------
module alul_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    alul_arbiter_if.slave bus,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [1:0]       alu_s_q;
    logic             rsp_valid_q, rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;

    logic             grant;
    logic             grant_vld;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [1:0]       sel_s;

`ifndef ALUL_ARB_FIXED_PRIORITY_EN
    // Last granted requester; resets to 1 so requester 0 wins the first tie.
    logic ptr_q;
`endif

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        grant     = 1'b0;
        grant_vld = |bus.req_valid;
        case (bus.req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
`ifdef ALUL_ARB_FIXED_PRIORITY_EN
            2'b11:   grant = 1'b0;
`else
            2'b11:   grant = ~ptr_q;
`endif
            default: grant = 1'b0;
        endcase
    end

    assign sel_a = grant ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
    assign sel_b = grant ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
    assign sel_s = grant ? bus.req_s[3:2] : bus.req_s[1:0];

    // Only IDLE accepts, and only the granted requester sees ready.
    always_comb begin
        bus.req_ready = 2'b00;
        if (state_q == IDLE && grant_vld) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = EXEC;
            EXEC:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
`ifndef ALUL_ARB_FIXED_PRIORITY_EN
            ptr_q       <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    // Operands only change on accept so the ALU stays quiet.
                    if (grant_vld) begin
                        alu_a_q  <= sel_a;
                        alu_b_q  <= sel_b;
                        alu_s_q  <= sel_s;
                        rsp_id_q <= grant;
                        cnt_q    <= LAT_M1;
`ifndef ALUL_ARB_FIXED_PRIORITY_EN
                        ptr_q    <= grant;
`endif
                    end
                end
                EXEC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_data_q  <= bus.alu_out;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_s     = alu_s_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != IDLE);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_alul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alul_arbiter
//   Directed bench for alul_arbiter. u1 runs with ALU_LAT=1, u4 with
//   ALU_LAT=4. A small ALU model closes each ALU loop. Expected responses
//   ({id, data}) are queued as ops are driven and popped on each response
//   handshake of u1.
// ---------------------------------------------------------------------------
module tb_alul_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy1, busy4;
    logic [1:0] st1, st4;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    alul_arbiter_if #(.WIDTH(8)) bus1 ();
    alul_arbiter_if #(.WIDTH(8)) bus4 ();

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] s);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign bus1.alu_out = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_s);
    assign bus4.alu_out = alu_model(bus4.alu_a, bus4.alu_b, bus4.alu_s);

    alul_arbiter #(.WIDTH(8), .ALU_LAT(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .busy(busy1), .state_dbg(st1)
    );

    alul_arbiter #(.WIDTH(8), .ALU_LAT(4)) u4 (
        .clk(clk), .rst(rst), .bus(bus4.slave), .busy(busy4), .state_dbg(st4)
    );

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic take_rsp();
        logic [8:0] e;
        total++;
        assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_rsp observed=%0h expected=none", {bus1.rsp_id, bus1.rsp_data});
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_id", bus1.rsp_id, e[8]);
            check("rsp_data", bus1.rsp_data, e[7:0]);
        end
    endtask

    // Advance one cycle; sample half a cycle after the active edge.
    task automatic step();
        @(negedge clk);
        #1;
        check("ready_not_both", bus1.req_ready == 2'b11, 1'b0);
        if (bus1.rsp_valid && bus1.rsp_ready) take_rsp();
    endtask

    task automatic run_until_empty(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            step();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        bus1.req_valid = 2'b00; bus1.req_a = '0; bus1.req_b = '0; bus1.req_s = '0;
        bus1.rsp_ready = 1'b1;
        bus4.req_valid = 2'b00; bus4.req_a = '0; bus4.req_b = '0; bus4.req_s = '0;
        bus4.rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, st1, 2'd0);
        check({tag, "_busy"}, busy1, 1'b0);
        check({tag, "_rsp_valid"}, bus1.rsp_valid, 1'b0);
        check({tag, "_rsp_id"}, bus1.rsp_id, 1'b0);
        check({tag, "_rsp_data"}, bus1.rsp_data, 8'h00);
        check({tag, "_alu_a"}, bus1.alu_a, 8'h00);
        check({tag, "_alu_b"}, bus1.alu_b, 8'h00);
        check({tag, "_alu_s"}, bus1.alu_s, 2'd0);
    endtask

    // Both requesters' operands for the contention scenarios.
    task automatic drive_both();
        bus1.req_a     = {8'hAA, 8'hF0};
        bus1.req_b     = {8'hFF, 8'h0F};
        bus1.req_s     = {2'd2, 2'd1};
        bus1.req_valid = 2'b11;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);

        // Reset values
        do_reset();
        check_reset_vals("reset");
        check("reset_ready", bus1.req_ready, 2'b00);

        // Single op, ALU_LAT=1: 0x0F AND 0x3C = 0x0C from requester 0
        bus1.req_a = {8'h00, 8'h0F}; bus1.req_b = {8'h00, 8'h3C}; bus1.req_s = 4'b0000;
        bus1.req_valid = 2'b01;
        #1;
        check("t1_ready", bus1.req_ready, 2'b01);
        exp_q.push_back({1'b0, 8'h0C});
        step();                                    // T+1
        bus1.req_valid = 2'b00;
        check("t1_busy_t1", busy1, 1'b1);
        check("t1_state_exec", st1, 2'd1);
        check("t1_rsp_valid_t1", bus1.rsp_valid, 1'b0);
        check("t1_alu_a", bus1.alu_a, 8'h0F);
        check("t1_alu_b", bus1.alu_b, 8'h3C);
        check("t1_alu_s", bus1.alu_s, 2'd0);
        step();                                    // T+2, response popped here
        check("t1_rsp_valid_t2", bus1.rsp_valid, 1'b1);
        check("t1_busy_t2", busy1, 1'b1);
        check("t1_queue_empty", exp_q.size(), 0);
        step();                                    // T+3
        check("t1_busy_t3", busy1, 1'b0);
        check("t1_rsp_valid_t3", bus1.rsp_valid, 1'b0);

        // Contention with both requesters continuously valid
        do_reset();
`ifdef ALUL_ARB_FIXED_PRIORITY_EN
        repeat (4) exp_q.push_back({1'b0, 8'hFF});
`else
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b1, 8'h55});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b1, 8'h55});
`endif
        drive_both();
        #1;
        check("t2_first_ready", bus1.req_ready, 2'b01);
        run_until_empty(40);
        bus1.req_valid = 2'b00;
        step();
        check("t2_idle_after", busy1, 1'b0);

        // Response backpressure: NOT 0x5A from requester 1
        bus1.rsp_ready = 1'b0;
        bus1.req_a = {8'h5A, 8'h00}; bus1.req_b = {8'h12, 8'h00}; bus1.req_s = 4'b1100;
        bus1.req_valid = 2'b10;
        #1;
        check("t3_ready_req1", bus1.req_ready, 2'b10);
        exp_q.push_back({1'b1, 8'hA5});
        step();                                    // EXEC
        bus1.req_a = {8'hC3, 8'h33}; bus1.req_b = {8'h00, 8'h0F}; bus1.req_s = 4'b0000;
        bus1.req_valid = 2'b01;
        #1;
        check("t3_no_ready_exec", bus1.req_ready, 2'b00);
        step();                                    // RESP
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", bus1.rsp_valid, 1'b1);
            check("t3_hold_data", bus1.rsp_data, 8'hA5);
            check("t3_hold_id", bus1.rsp_id, 1'b1);
            check("t3_hold_no_ready", bus1.req_ready, 2'b00);
            check("t3_hold_alu_a", bus1.alu_a, 8'h5A);
            step();
        end
        bus1.rsp_ready = 1'b1;
        #1;
        take_rsp();
        step();                                    // back in IDLE
        check("t3_idle_state", st1, 2'd0);
        check("t3_pending_ready", bus1.req_ready, 2'b01);
        exp_q.push_back({1'b0, 8'h03});
        step();
        bus1.req_valid = 2'b00;
        run_until_empty(10);
        step();

        // ALU_LAT=4 on u4: 0x00 XOR 0xFF
        bus4.req_a = {8'h00, 8'h00}; bus4.req_b = {8'h00, 8'hFF}; bus4.req_s = 4'b0010;
        bus4.req_valid = 2'b01;
        bus4.rsp_ready = 1'b1;
        #1;
        check("t4_ready", bus4.req_ready, 2'b01);
        step();                                    // T+1
        bus4.req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            check("t4_alu_a", bus4.alu_a, 8'h00);
            check("t4_alu_b", bus4.alu_b, 8'hFF);
            check("t4_alu_s", bus4.alu_s, 2'd2);
            check("t4_no_rsp", bus4.rsp_valid, 1'b0);
            check("t4_busy", busy4, 1'b1);
            step();
        end
        check("t4_rsp_valid", bus4.rsp_valid, 1'b1); // T+5
        check("t4_rsp_data", bus4.rsp_data, 8'hFF);
        check("t4_rsp_id", bus4.rsp_id, 1'b0);
        step();
        check("t4_rsp_done", bus4.rsp_valid, 1'b0);

        // Reset while in EXEC
        bus1.rsp_ready = 1'b1;
        bus1.req_a = {8'h77, 8'h00}; bus1.req_b = {8'h08, 8'h00}; bus1.req_s = 4'b0100;
        bus1.req_valid = 2'b10;
        step();
        bus1.req_valid = 2'b00;
        check("t5_in_exec", st1, 2'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("t5");
        step();
        step();
        check("t5_no_rsp", bus1.rsp_valid, 1'b0);
        drive_both();
        #1;
        check("t5_tie_ready", bus1.req_ready, 2'b01);
        exp_q.push_back({1'b0, 8'hFF});
        step();
        bus1.req_valid = 2'b00;
        run_until_empty(10);
        step();

`ifdef ALUL_ARB_FIXED_PRIORITY_EN
        // Fixed priority: three ties all to requester 0, then requester 1
        do_reset();
        repeat (3) exp_q.push_back({1'b0, 8'hFF});
        drive_both();
        run_until_empty(30);
        bus1.req_valid = 2'b10;
        exp_q.push_back({1'b1, 8'h55});
        run_until_empty(10);
        bus1.req_valid = 2'b00;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alul_arbiter.md
Name: alul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit logic ALU (ALUL: AND/OR/XOR/NOT A, select S[1:0]) between two requesters.
- Accepts one operation at a time over a valid/ready channel and drives registered operands and select into the ALU.
- Waits a fixed settle time, captures ALU OUT, and returns the result with the requester ID on a shared response channel.
- Sits between the ALU and its client blocks; the ALU is instantiated outside this block.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU instance.
- ALU_LAT, 1, cycles operands are held stable before OUT is captured; legal range 1..15.

Ports:
- CLK, input, 1, sole clock; all logic on rising edge.
- RST, input, 1, synchronous active-high reset.
- REQ_VALID, input, 2, bit i = requester i has an op pending.
- REQ_READY, output, 2, bit i = op from requester i accepted this cycle.
- REQ_A, input, 2*WIDTH, operand A; requester i in bits [i*WIDTH +: WIDTH].
- REQ_B, input, 2*WIDTH, operand B; same packing as REQ_A.
- REQ_S, input, 4, op select; requester i in bits [2i +: 2]. 0=AND, 1=OR, 2=XOR, 3=NOT A.
- ALU_A, output, WIDTH, registered operand to ALU A.
- ALU_B, output, WIDTH, registered operand to ALU B.
- ALU_S, output, 2, registered select to ALU S.
- ALU_OUT, input, WIDTH, ALU OUT; treated as combinational from ALU_A/B/S.
- RSP_VALID, output, 1, response available.
- RSP_READY, input, 1, consumer accepts the response.
- RSP_ID, output, 1, requester that issued the op.
- RSP_DATA, output, WIDTH, captured ALU result.
- BUSY, output, 1, high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high; it is sampled on the CLK rising edge and overrides every other action.
- Reset values: state=IDLE; ALU_A=0, ALU_B=0, ALU_S=0; RSP_VALID=0, RSP_ID=0, RSP_DATA=0; BUSY=0; last-grant pointer=1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant:
  - Grant g is chosen combinationally from REQ_VALID.
  - Exactly one bit set: that requester wins.
  - Both bits set: the requester that is not the last-grant pointer wins.
  - REQ_READY[g]=1 in IDLE when REQ_VALID[g]=1; REQ_READY is 0 in every other state.
- IDLE, accept (on the edge): latch REQ_A/B/S of g into ALU_A/B/S; RSP_ID<=g; pointer<=g; counter<=ALU_LAT-1; go to EXEC.
- IDLE, no request: ALU_A/B/S hold their previous values, so the ALU does not toggle.
- EXEC:
  - ALU_A/B/S are stable.
  - Counter nonzero: decrement.
  - Counter zero: RSP_DATA<=ALU_OUT, RSP_VALID<=1, go to RESP.
- RESP:
  - RSP_VALID, RSP_ID and RSP_DATA are held stable until RSP_READY=1.
  - On RSP_VALID & RSP_READY: RSP_VALID<=0, go to IDLE.
- Latency: op accepted in cycle T gives RSP_VALID=1 from cycle T+1+ALU_LAT.
- Throughput: minimum ALU_LAT+2 cycles per op when RSP_READY is tied high. There is no new accept in the cycle the response handshakes; the next accept happens in IDLE.
- REQ_VALID dropped before grant: no accept, no state change.
- REQ_VALID changes during EXEC/RESP: ignored. Latched operands are unaffected.
- Pointer update: pointer changes only on accept, never on an ungranted cycle.
- Reset mid-operation (EXEC or RESP): the op is discarded with no response, and all reset values above apply.
- Width: bitwise ops only; no carry or overflow. RSP_DATA is exactly ALU_OUT at capture.

Optional Feature:
- Macro: ALUL_ARB_FIXED_PRIORITY_EN.
- Defined: requester 0 always wins when both REQ_VALID bits are set. The pointer register is removed, and requester 1 is granted only when REQ_VALID[0]=0.
- Not defined: round-robin exactly as in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then single op, ALU_LAT=1. Req0: A=0x0F, B=0x3C, S=0 (AND), accepted at T. Expect RSP_VALID at T+2, RSP_DATA=0x0C, RSP_ID=0; BUSY high T+1..T+2.
- Contention, round-robin, RSP_READY=1.
  - Both valid continuously: req0 A=0xF0, B=0x0F, S=1 (OR); req1 A=0xAA, B=0xFF, S=2 (XOR).
  - Expect grants 0,1,0,1 with responses 0xFF(ID0), 0x55(ID1), 0xFF(ID0), 0x55(ID1).
  - Expect REQ_READY never high for both bits in the same cycle.
- Response backpressure.
  - Req1: A=0x5A, S=3 (NOT A); hold RSP_READY=0 for 5 cycles.
  - Expect RSP_VALID held with RSP_DATA=0xA5, RSP_ID=1 throughout.
  - Expect REQ_READY=0 for a pending req0 until the handshake completes.
- ALU_LAT=4.
  - Req0: A=0x00, B=0xFF, S=2 (XOR).
  - Expect ALU_A/B/S stable for 4 cycles and RSP_VALID at T+5 with RSP_DATA=0xFF.
- Reset mid-operation.
  - Assert RST for 1 cycle while in EXEC.
  - Expect no response, all outputs at reset values on the next cycle.
  - Expect a subsequent tie to be won by requester 0.
- ALUL_ARB_FIXED_PRIORITY_EN defined.
  - Both requesters valid for 3 ops.
  - Expect all three grants to requester 0 and requester 1 granted only after REQ_VALID[0] drops.
